// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-partition error monitor.
// Helpers take 32-bit operands so they can be reused at any width up to 32.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  // Sum clamped at lim; the 33-bit sum keeps the carry out so it cannot wrap.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] lim);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

endpackage

// File: rtl/err_metric_stage.sv
// Per-pattern error metrics between exact and approximate outputs,
// registered together with a valid bit.
module err_metric_stage
  import approx_eval_pkg::*;
#(
  parameter  int NUM_OUT = 4,
  localparam int HD_W    = clog2(NUM_OUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_OUT-1:0] po_exact,
  input  logic [NUM_OUT-1:0] po_approx,
  output logic               vld,
  output logic               mism,
  output logic [HD_W-1:0]    hd,
  output logic [NUM_OUT-1:0] abs_err
);

  logic [NUM_OUT-1:0] diff_x;
  logic [NUM_OUT-1:0] abs_d;
  logic [HD_W-1:0]    hd_d;

  for (genvar b = 0; b < NUM_OUT; b++) begin : g_xor
    assign diff_x[b] = po_exact[b] ^ po_approx[b];
  end

  assign abs_d = (po_exact >= po_approx) ? (po_exact - po_approx)
                                         : (po_approx - po_exact);
  assign hd_d  = HD_W'(popcount(32'(diff_x)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld     <= 1'b0;
      mism    <= 1'b0;
      hd      <= '0;
      abs_err <= '0;
    end else begin
      vld <= en;
      if (en) begin
        mism    <= |diff_x;
        hd      <= hd_d;
        abs_err <= abs_d;
      end
    end
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Sweeps all 2**NUM_IN patterns through an exact/approximate partition pair
// and accumulates saturating mismatch, Hamming and absolute-error metrics.
module approx_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int NUM_IN  = 7,
  parameter int NUM_OUT = 4,
  parameter int ACC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [NUM_IN-1:0]  pi_out,
  input  logic [NUM_OUT-1:0] po_exact,
  input  logic [NUM_OUT-1:0] po_approx,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   err_count,
  output logic [ACC_W-1:0]   hd_sum,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [NUM_OUT-1:0] max_abs_err
);

  localparam int                HD_W    = clog2(NUM_OUT + 1);
  localparam logic [NUM_IN-1:0] PI_LAST = '1;
  localparam logic [31:0]       ACC_LIM = (ACC_W >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << ACC_W) - 32'd1);

  state_t             state, state_nxt;
  logic               start_ok;
  logic               st_vld, st_mism;
  logic [HD_W-1:0]    st_hd;
  logic [NUM_OUT-1:0] st_abs;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (pi_out == PI_LAST) state_nxt = DRAIN;
      DRAIN:      state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Pattern counter wraps naturally to 0 on the final RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                pi_out <= '0;
    else if (start_ok)      pi_out <= '0;
    else if (state == RUN)  pi_out <= pi_out + 1'b1;
  end

  err_metric_stage #(.NUM_OUT(NUM_OUT)) u_stage (
    .clk       (clk),
    .rst       (rst),
    .en        (state == RUN),
    .po_exact  (po_exact),
    .po_approx (po_approx),
    .vld       (st_vld),
    .mism      (st_mism),
    .hd        (st_hd),
    .abs_err   (st_abs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count   <= '0;
      hd_sum      <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else if (start_ok) begin
      err_count   <= '0;
      hd_sum      <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else if (st_vld) begin
      err_count   <= ACC_W'(sat_add(32'(err_count),   {31'd0, st_mism}, ACC_LIM));
      hd_sum      <= ACC_W'(sat_add(32'(hd_sum),      32'(st_hd),       ACC_LIM));
      sum_abs_err <= ACC_W'(sat_add(32'(sum_abs_err), 32'(st_abs),      ACC_LIM));
      if (st_abs > max_abs_err) max_abs_err <= st_abs;
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Scoreboard bench: expected sweep totals queued at start, checked on done.
module tb_approx_error_monitor;
  localparam int NI = 7;
  localparam int NO = 4;
  localparam int N  = 128;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  logic [NI-1:0] pi_a, pi_b;
  logic [NO-1:0] pe_a, pa_a, pe_b, pa_b;
  logic          busy_a, done_a, busy_b, done_b;
  logic [15:0]   ec_a, hd_a, sa_a;
  logic [7:0]    ec_b, hd_b, sa_b;
  logic [NO-1:0] mx_a, mx_b;

  int            mode;
  logic [NO-1:0] tbl [N];
  int            n_vec = 0;
  int            n_err = 0;

  typedef struct {
    int ec16, hd16, sa16, mx, ec8, hd8, sa8;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  function automatic logic [NO-1:0] approx_of(input int m, input logic [NI-1:0] p);
    case (m)
      0:       return p[3:0];
      1:       return p[3:0] ^ 4'b0001;
      2:       return 4'd0;
      default: return tbl[p];
    endcase
  endfunction

  assign pe_a = pi_a[3:0];
  assign pa_a = approx_of(mode, pi_a);
  assign pe_b = pi_b[3:0];
  assign pa_b = approx_of(mode, pi_b);

  approx_error_monitor #(.NUM_IN(NI), .NUM_OUT(NO), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .pi_out(pi_a),
    .po_exact(pe_a), .po_approx(pa_a), .busy(busy_a), .done(done_a),
    .err_count(ec_a), .hd_sum(hd_a), .sum_abs_err(sa_a), .max_abs_err(mx_a)
  );

  approx_error_monitor #(.NUM_IN(NI), .NUM_OUT(NO), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .pi_out(pi_b),
    .po_exact(pe_b), .po_approx(pa_b), .busy(busy_b), .done(done_b),
    .err_count(ec_b), .hd_sum(hd_b), .sum_abs_err(sa_b), .max_abs_err(mx_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int m);
    exp_t r;
    int ec, hd, sa, mx, d;
    logic [NO-1:0] x, a, b;
    ec = 0; hd = 0; sa = 0; mx = 0;
    for (int p = 0; p < N; p++) begin
      a = 4'(p);
      b = approx_of(m, 7'(p));
      x = a ^ b;
      if (a != b) ec++;
      for (int i = 0; i < NO; i++) hd += int'(x[i]);
      d = int'(a) - int'(b);
      if (d < 0) d = -d;
      sa += d;
      if (d > mx) mx = d;
    end
    r.ec16 = (ec > 65535) ? 65535 : ec;
    r.hd16 = (hd > 65535) ? 65535 : hd;
    r.sa16 = (sa > 65535) ? 65535 : sa;
    r.ec8  = (ec > 255) ? 255 : ec;
    r.hd8  = (hd > 255) ? 255 : hd;
    r.sa8  = (sa > 255) ? 255 : sa;
    r.mx   = mx;
    return r;
  endfunction

  // Result monitor: pop expectations on each rising done.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done_a && !done_prev) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", {31'd0, done_a}, 0);
      end else begin
        e = sb.pop_front();
        chk("err_count16", ec_a, e.ec16);
        chk("hd_sum16",    hd_a, e.hd16);
        chk("sum_abs16",   sa_a, e.sa16);
        chk("max_abs16",   mx_a, e.mx);
        chk("err_count8",  ec_b, e.ec8);
        chk("hd_sum8",     hd_b, e.hd8);
        chk("sum_abs8",    sa_b, e.sa8);
        chk("max_abs8",    mx_b, e.mx);
        chk("done8",       {31'd0, done_b}, 1);
      end
    end
    done_prev = done_a;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_pi"},   pi_a, 0);
    chk({tag, "_busy"}, {31'd0, busy_a}, 0);
    chk({tag, "_done"}, {31'd0, done_a}, 0);
    chk({tag, "_ec"},   ec_a, 0);
    chk({tag, "_hd"},   hd_a, 0);
    chk({tag, "_sa"},   sa_a, 0);
    chk({tag, "_mx"},   mx_a, 0);
    chk({tag, "_ec8"},  ec_b, 0);
  endtask

  task automatic sweep(input int m, input bit extra_starts);
    mode = m;
    sb.push_back(model(m));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int j = 0; j <= N + 1; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 0) begin
        chk("clr_ec", ec_a, 0);
        chk("clr_hd", hd_a, 0);
        chk("clr_sa", sa_a, 0);
        chk("clr_mx", mx_a, 0);
      end
      if (j <= N) begin
        chk("pi_seq", pi_a, j % N);
        chk("busy_run", {31'd0, busy_a}, 1);
        chk("done_run", {31'd0, done_a}, 0);
      end else begin
        chk("busy_end", {31'd0, busy_a}, 0);
        chk("done_end", {31'd0, done_a}, 1);
      end
      start = extra_starts && (j == 9 || j == 99);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) tbl[i] = 4'($urandom_range(0, 15));
    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    sweep(0, 1'b0);
    sweep(1, 1'b0);
    sweep(2, 1'b0);

    // Abort a sweep with reset at E60, then rerun cleanly.
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (59) @(negedge clk);
    chk("pi_pre_rst", pi_a, 59);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk_zero("abort");
    @(negedge clk); rst = 1'b0;
    sweep(2, 1'b0);

    sweep(3, 1'b1);
    sweep(1, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
